// File: rtl/noise_pkg.sv
// Shared state encoding, default sizing and round-robin helper for the noise-generator arbiter.
`timescale 1ns/1ps
package noise_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 16;
  localparam int TMO_DEF   = 15;
  localparam int NREQ_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_e;

  // First set bit at or after (last+1) mod n, wrapping; the reverse scan leaves the closest hit.
  function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [2:0] pick;
    int idx;
    pick = last;
    for (int k = NREQ_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/noise_get_arbiter_if.sv
// Requester, generator and result signals of the arbiter; slave is the arbiter's view.
`timescale 1ns/1ps
interface noise_get_arbiter_if
  import noise_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  logic [NREQ-1:0]  get;
  logic             gen_get;
  logic [WIDTH-1:0] gen_data;
  logic             gen_valid;
  logic [WIDTH-1:0] data;
  logic [NREQ-1:0]  ack;
  logic             busy;
  logic             err;

  modport master (output get, gen_data, gen_valid,
                  input  gen_get, data, ack, busy, err);
  modport slave  (input  get, gen_data, gen_valid,
                  output gen_get, data, ack, busy, err);
endinterface

// File: rtl/get_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous request line.
// Edge appears two clocks after the input is first sampled high.
`timescale 1ns/1ps
module get_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic get_i,
  output logic edge_o
);
  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] arm_q;

  // prev is held high until the synchronizer has refilled, so a level already
  // asserted at reset release never looks like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b1;
      arm_q  <= 2'b00;
    end else begin
      meta_q <= get_i;
      sync_q <= meta_q;
      prev_q <= sync_q | ~arm_q[1];
      arm_q  <= {arm_q[0], 1'b1};
    end
  end

  assign edge_o = sync_q & ~prev_q;
endmodule

// File: rtl/noise_get_arbiter.sv
// Round-robin arbiter sharing one noise generator among NREQ asynchronous requesters.
// Edge to gen_get is 2 clocks when idle; gen_get to ack is generator latency + 1.
`timescale 1ns/1ps
module noise_get_arbiter
  import noise_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int TMO   = TMO_DEF
) (
  input logic                clk,
  input logic                rst,
  noise_get_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  state_e                state_q, state_d;
  logic [NREQ-1:0]       pending_q, pending_d;
  logic [NREQ-1:0]       edge_s;
  logic [NREQ-1:0]       clr;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  err_q, err_d;
  logic [NREQ_MAX-1:0]   req_w;

  for (genvar i = 0; i < NREQ; i++) begin : g_sync
    get_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .get_i  (bus.get[i]),
      .edge_o (edge_s[i])
    );
  end

  assign req_w = NREQ_MAX'(pending_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d = GW'(rr_pick(req_w, 3'(last_q), NREQ));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(TMO);
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.gen_valid) begin
          data_d  = bus.gen_data;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // Counter reaching zero ends the window; a sample in that last cycle still counts.
          if (cnt_q == CW'(1)) begin
            err_d        = 1'b1;
            clr[grant_q] = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      DELIVER: begin
        clr[grant_q] = 1'b1;
        last_d       = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the clearing cycle must survive, so the set term is ORed last.
    pending_d = (pending_q & ~clr) | edge_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      last_q    <= GW'(NREQ - 1);
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign bus.gen_get = (state_q == ISSUE);
  assign bus.ack     = (state_q == DELIVER) ? (NREQ'(1) << grant_q) : '0;
  assign bus.data    = data_q;
  assign bus.busy    = (|pending_q) || (state_q != IDLE);
  assign bus.err     = err_q;
endmodule

// File: doc/noise_get_arbiter.md
NOISE_GET_ARBITER -- requirements
Module: noise_get_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 16, SHALL set the generator sample width.
REQ-003 Parameter TMO, default 15, SHALL set the generator-response timeout in clocks.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge clocked.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 get  input  NREQ  SHALL carry per-requester asynchronous request pulses; pulses are at least one clk period wide.
REQ-007 gen_get  output  1  SHALL be a one-cycle strobe asking the shared generator for a new sample.
REQ-008 gen_data  input  WIDTH  SHALL carry the generator sample, qualified by gen_valid.
REQ-009 gen_valid  input  1  SHALL be a one-cycle strobe from the generator, 1..TMO cycles after gen_get.
REQ-010 data  output  WIDTH  SHALL hold the last sample delivered.
REQ-011 ack  output  NREQ  SHALL give a one-hot, one-cycle strobe marking the requester that owns data.
REQ-012 busy  output  1  SHALL be high whenever any request is pending or the FSM is not IDLE.
REQ-013 err  output  1  SHALL be a sticky flag set on timeout, cleared only by rst.

Function
REQ-014 Each get bit SHALL pass a two-flop synchronizer, then a rising-edge detector; the detected edge sets pending[i].
REQ-015 A new edge on a requester already pending SHALL be merged (no second sample, no error).
REQ-016 FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER.
REQ-017 IDLE: if any pending bit is set, latch grant index by round-robin and go to ISSUE; otherwise stay.
REQ-018 Round-robin SHALL search from (last_grant+1) mod NREQ upward with wrap; after reset last_grant = NREQ-1, so requester 0 wins first.
REQ-019 ISSUE: assert gen_get for exactly one cycle, load timeout counter with TMO, go to WAIT.
REQ-020 WAIT: on gen_valid, register gen_data into data and go to DELIVER; gen_valid in any other state SHALL be ignored.
REQ-021 WAIT: counter decrements each cycle without gen_valid; at zero, set err, clear the granted pending bit, go to IDLE with no ack and data unchanged.
REQ-022 DELIVER: pulse ack[grant] for one cycle with data already valid, clear pending[grant], update last_grant, go to IDLE.
REQ-023 Latency from synchronized edge to gen_get SHALL be 2 cycles when idle (IDLE then ISSUE); gen_get to ack SHALL be generator latency + 1 cycle.
REQ-024 An edge on the granted requester arriving in the same cycle its pending bit clears SHALL leave pending set (set wins).
REQ-025 Simultaneous edges on several requesters SHALL all be latched and served in round-robin order, one sample each.

Reset
REQ-026 While rst is high: state = IDLE, pending = 0, synchronizers = 0, last_grant = NREQ-1, counter = 0, data = 0, ack = 0, gen_get = 0, busy = 0, err = 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; a gen_valid arriving after release with no outstanding gen_get SHALL be ignored.
REQ-028 A get level already high at reset release SHALL NOT produce an edge (synchronizers reset to 0 and its first sample is masked one cycle).

Structure
REQ-029 FSM state encoding and the default NREQ/WIDTH/TMO SHALL live in a shared package, noise_pkg.
REQ-030 Synchronizer plus edge detector SHALL be one sub-module, get_sync_edge, instantiated NREQ times.

Verification
REQ-031 Single get[0] pulse 25 ns, generator latency 1 -> one gen_get, ack = 0001, data = gen_data, busy returns low.
REQ-032 get = 1111 in one cycle -> four gen_get strobes, acks in order 0001, 0010, 0100, 1000.
REQ-033 get[2] pulsed twice while pending -> exactly one ack on bit 2.
REQ-034 Generator never answers, TMO = 15 -> err high 16 cycles after gen_get, no ack, FSM back to IDLE and serves next request.
REQ-035 rst asserted in WAIT, late gen_valid after release -> no ack, data = 0, err = 0.
REQ-036 Seven periodic get[1] pulses (125 ns period, clk 20 ns) -> seven acks on bit 1, err = 0.
